// File: rtl/aqms_pkg.sv
// Shared definitions for the AQMS SRAM arbiter: the DMA state encoding
// and the SRAM address width.
package aqms_pkg;

    localparam int SRAM_ADDR_W = 19;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        RECOVER = 2'd2
    } dma_state_t;

endpackage

// File: rtl/aqms_ram_arbiter.sv
// Shares the external SRAM between the Z80 ebus and the ESP DMA port.
// The CPU owns the pins combinationally whenever it selects the RAM and
// is never stalled; DMA cycles run only in CPU-idle windows and are
// aborted (then retried) if the CPU shows up mid-strobe.
//
// DMA handshake: dma_req is a level that the requester holds, together
// with dma_wr/dma_addr/dma_wrdata, until it sees the one-cycle dma_ack
// pulse. Address, data and direction are latched when the cycle starts,
// so the requester may change them in the ack cycle. dma_rddata is valid
// in the ack cycle of a read and holds until the next read completes.
module aqms_ram_arbiter
    import aqms_pkg::*;
#(
    parameter int ADDR_W          = SRAM_ADDR_W,
    parameter int STROBE_CYCLES   = 3,
    parameter int RECOVERY_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_sel,
    input  logic              cpu_wr_n,
    input  logic              cpu_wr_allow,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wrdata,
    input  logic              dma_req,
    input  logic              dma_wr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wrdata,
    output logic              dma_ack,
    output logic [7:0]        dma_rddata,
    output logic [ADDR_W-1:0] ram_a,
    input  logic [7:0]        ram_d_in,
    output logic [7:0]        ram_d_out,
    output logic              ram_d_oe,
    output logic              ram_ce_n,
    output logic              ram_we_n,
    output logic              ram_oe_n,
    output logic              busy,
    output dma_state_t        dbg_state
);

    localparam int CNT_MAX = (STROBE_CYCLES > RECOVERY_CYCLES) ? STROBE_CYCLES : RECOVERY_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] STROBE_LOAD  = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'((RECOVERY_CYCLES > 0) ? RECOVERY_CYCLES - 1 : 0);

    dma_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wrdata;
    logic              r_wr;
    logic              r_ack;
    logic [7:0]        r_rddata;

    dma_state_t        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_latch;
    logic              w_done;

    // Next-state logic: start only when the CPU is idle, abort on any CPU
    // access during the strobe, count down strobe and recovery windows.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (dma_req && !cpu_sel) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = STROBE_LOAD;
                    w_state_nxt = STROBE;
                end
            end
            STROBE: begin
                if (cpu_sel) begin
                    // CPU took the pins; drop this attempt, request stays pending.
                    w_state_nxt = IDLE;
                end else if (r_cnt == '0) begin
                    w_done = 1'b1;
                    if (RECOVERY_CYCLES == 0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt   = RECOVER_LOAD;
                        w_state_nxt = RECOVER;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RECOVER: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counter, request latch, ack pulse and read-data capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wrdata <= 8'h00;
            r_wr     <= 1'b0;
            r_ack    <= 1'b0;
            r_rddata <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_done;
            if (w_latch) begin
                r_addr   <= dma_addr;
                r_wrdata <= dma_wrdata;
                r_wr     <= dma_wr;
            end
            if (w_done && !r_wr) begin
                r_rddata <= ram_d_in;
            end
        end
    end

    // Pin mux: CPU overrides everything combinationally; otherwise the
    // latched DMA cycle drives the pins with strobes only while in STROBE.
    always_comb begin
        ram_a     = r_addr;
        ram_d_out = r_wrdata;
        ram_ce_n  = 1'b1;
        ram_we_n  = 1'b1;
        ram_oe_n  = 1'b1;
        ram_d_oe  = 1'b0;
        if (cpu_sel) begin
            ram_a     = cpu_addr;
            ram_d_out = cpu_wrdata;
            ram_ce_n  = 1'b0;
            ram_we_n  = !(!cpu_wr_n && cpu_wr_allow);
            ram_oe_n  = !cpu_wr_n;
            ram_d_oe  = !cpu_wr_n && cpu_wr_allow;
        end else if (r_state == STROBE) begin
            ram_ce_n = 1'b0;
            ram_we_n = !r_wr;
            ram_oe_n = r_wr;
            ram_d_oe = r_wr;
        end
    end

    assign dma_ack    = r_ack;
    assign dma_rddata = r_rddata;
    assign busy       = (r_state != IDLE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_aqms_ram_arbiter.sv
// Bench for aqms_ram_arbiter: SRAM model on the pins, a reference memory
// for expected read data, and an ack-driven scoreboard for dma_rddata.
module tb_aqms_ram_arbiter;
    import aqms_pkg::*;

    localparam int AW = 19;

    logic          clk;
    logic          reset;
    logic          cpu_sel;
    logic          cpu_wr_n;
    logic          cpu_wr_allow;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wrdata;
    logic          dma_req;
    logic          dma_wr;
    logic [AW-1:0] dma_addr;
    logic [7:0]    dma_wrdata;
    logic          dma_ack;
    logic [7:0]    dma_rddata;
    logic [AW-1:0] ram_a;
    logic [7:0]    ram_d_in;
    logic [7:0]    ram_d_out;
    logic          ram_d_oe;
    logic          ram_ce_n;
    logic          ram_we_n;
    logic          ram_oe_n;
    logic          busy;
    dma_state_t    dbg_state;

    int vec_cnt = 0;
    int err_cnt = 0;
    int ack_cnt = 0;
    int cyc     = 0;

    logic [7:0] exp_q[$];
    logic [7:0] ref_mem[int];
    logic [7:0] last_rd;
    logic [7:0] mem [0:(1<<AW)-1];

    aqms_ram_arbiter #(
        .ADDR_W          (AW),
        .STROBE_CYCLES   (3),
        .RECOVERY_CYCLES (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_sel      (cpu_sel),
        .cpu_wr_n     (cpu_wr_n),
        .cpu_wr_allow (cpu_wr_allow),
        .cpu_addr     (cpu_addr),
        .cpu_wrdata   (cpu_wrdata),
        .dma_req      (dma_req),
        .dma_wr       (dma_wr),
        .dma_addr     (dma_addr),
        .dma_wrdata   (dma_wrdata),
        .dma_ack      (dma_ack),
        .dma_rddata   (dma_rddata),
        .ram_a        (ram_a),
        .ram_d_in     (ram_d_in),
        .ram_d_out    (ram_d_out),
        .ram_d_oe     (ram_d_oe),
        .ram_ce_n     (ram_ce_n),
        .ram_we_n     (ram_we_n),
        .ram_oe_n     (ram_oe_n),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model driven purely by the pins
    assign ram_d_in = mem[ram_a];
    always @(posedge clk) begin
        if (!ram_ce_n && !ram_we_n) mem[ram_a] <= ram_d_out;
    end

    // Scoreboard: every ack pops one expected dma_rddata value
    always @(negedge clk) begin
        if (dma_ack) begin
            ack_cnt++;
            vec_cnt++;
            if (exp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL unexpected_ack: ack seen with empty queue, rddata=%h", dma_rddata);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (dma_rddata !== e) begin
                    err_cnt++;
                    $display("FAIL ack_rddata: got %h expected %h", dma_rddata, e);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
    endfunction

    // Present a request and record the expected rddata at ack time
    task automatic post_req(input logic wr, input logic [AW-1:0] a, input logic [7:0] d);
        dma_wr     = wr;
        dma_addr   = a;
        dma_wrdata = d;
        dma_req    = 1'b1;
        if (wr) begin
            ref_mem[int'(a)] = d;
        end else begin
            last_rd = ref_rd(a);
        end
        exp_q.push_back(last_rd);
    endtask

    // Wait (bounded) for dma_ack, then release the request
    task automatic wait_ack(input string name);
        bit got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (dma_ack) got = 1;
            else tick();
        end
        vec_cnt++;
        if (!got) begin
            err_cnt++;
            $display("FAIL %s_timeout: no dma_ack within 60 cycles, busy=%b", name, busy);
        end
        dma_req = 1'b0;
        tick();
    endtask

    task automatic do_dma(input logic wr, input logic [AW-1:0] a, input logic [7:0] d);
        post_req(wr, a, d);
        tick();
        wait_ack("do_dma");
        vec_cnt++;
        if (dma_ack !== 1'b0) begin
            err_cnt++;
            $display("FAIL ack_width: dma_ack=%b one cycle after ack, required 0", dma_ack);
        end
    endtask

    task automatic test_reset;
        #1;
        vec_cnt++;
        if ({dma_ack, dma_rddata, busy, ram_ce_n, ram_we_n, ram_oe_n, ram_d_oe, ram_a} !==
            {1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 19'h0}) begin
            err_cnt++;
            $display("FAIL reset_values: ack=%b rd=%h busy=%b ce=%b we=%b oe=%b doe=%b a=%h",
                     dma_ack, dma_rddata, busy, ram_ce_n, ram_we_n, ram_oe_n, ram_d_oe, ram_a);
        end
        tick();
        reset = 1'b0;
        tick();
        vec_cnt++;
        if (busy !== 1'b0 || ram_ce_n !== 1'b1 || dbg_state !== IDLE) begin
            err_cnt++;
            $display("FAIL post_reset_idle: busy=%b ce_n=%b state=%0d required 0/1/0", busy, ram_ce_n, dbg_state);
        end
    endtask

    task automatic test_dma_write_read;
        post_req(1'b1, 19'h12345, 8'hA5);
        for (int k = 1; k <= 3; k++) begin
            tick();
            vec_cnt++;
            if ({ram_ce_n, ram_we_n, ram_oe_n, ram_d_oe, busy, dma_ack} !== 6'b001110 ||
                ram_a !== 19'h12345 || ram_d_out !== 8'hA5) begin
                err_cnt++;
                $display("FAIL wr_strobe%0d: ce=%b we=%b oe=%b doe=%b busy=%b ack=%b a=%h d=%h required 0 0 1 1 1 0 12345 a5",
                         k, ram_ce_n, ram_we_n, ram_oe_n, ram_d_oe, busy, dma_ack, ram_a, ram_d_out);
            end
        end
        tick();
        vec_cnt++;
        if ({ram_ce_n, ram_we_n, ram_d_oe, dma_ack} !== 4'b1101) begin
            err_cnt++;
            $display("FAIL wr_ack_cycle: ce=%b we=%b doe=%b ack=%b required 1 1 0 1",
                     ram_ce_n, ram_we_n, ram_d_oe, dma_ack);
        end
        dma_req = 1'b0;
        tick();
        vec_cnt++;
        if (dma_ack !== 1'b0) begin
            err_cnt++;
            $display("FAIL wr_ack_width: ack=%b required 0", dma_ack);
        end
        do_dma(1'b0, 19'h12345, 8'h00);
    endtask

    task automatic test_cpu_preempt;
        int acks0;
        post_req(1'b0, 19'h12345, 8'h00);
        tick();
        tick();
        cpu_sel  = 1'b1;
        cpu_wr_n = 1'b1;
        cpu_addr = 19'h04000;
        #1;
        acks0 = ack_cnt;
        vec_cnt++;
        if (ram_a !== 19'h04000 || {ram_ce_n, ram_oe_n, ram_we_n, ram_d_oe} !== 4'b0010) begin
            err_cnt++;
            $display("FAIL preempt_pins: a=%h ce=%b oe=%b we=%b doe=%b required 04000 0 0 1 0",
                     ram_a, ram_ce_n, ram_oe_n, ram_we_n, ram_d_oe);
        end
        tick();
        tick();
        tick();
        vec_cnt++;
        if (busy !== 1'b0 || ack_cnt !== acks0) begin
            err_cnt++;
            $display("FAIL preempt_abort: busy=%b acks=%0d required 0 and %0d", busy, ack_cnt, acks0);
        end
        cpu_sel = 1'b0;
        tick();
        vec_cnt++;
        if (busy !== 1'b1 || ram_a !== 19'h12345 || ram_oe_n !== 1'b0) begin
            err_cnt++;
            $display("FAIL preempt_retry: busy=%b a=%h oe=%b required 1 12345 0", busy, ram_a, ram_oe_n);
        end
        wait_ack("preempt");
    endtask

    task automatic test_cpu_write_allow;
        cpu_sel      = 1'b1;
        cpu_wr_n     = 1'b0;
        cpu_wr_allow = 1'b0;
        cpu_addr     = 19'h00100;
        cpu_wrdata   = 8'h66;
        #1;
        vec_cnt++;
        if ({ram_ce_n, ram_we_n, ram_oe_n, ram_d_oe} !== 4'b0110) begin
            err_cnt++;
            $display("FAIL cpu_wr_blocked: ce=%b we=%b oe=%b doe=%b required 0 1 1 0",
                     ram_ce_n, ram_we_n, ram_oe_n, ram_d_oe);
        end
        tick();
        cpu_wr_allow = 1'b1;
        cpu_wrdata   = 8'h77;
        ref_mem[32'h100] = 8'h77;
        #1;
        vec_cnt++;
        if ({ram_ce_n, ram_we_n, ram_oe_n, ram_d_oe} !== 4'b0011 ||
            ram_d_out !== 8'h77 || ram_a !== 19'h00100) begin
            err_cnt++;
            $display("FAIL cpu_wr_allowed: ce=%b we=%b oe=%b doe=%b d=%h a=%h required 0 0 1 1 77 00100",
                     ram_ce_n, ram_we_n, ram_oe_n, ram_d_oe, ram_d_out, ram_a);
        end
        tick();
        cpu_sel      = 1'b0;
        cpu_wr_n     = 1'b1;
        cpu_wr_allow = 1'b0;
        tick();
        do_dma(1'b0, 19'h00100, 8'h00);
    endtask

    task automatic test_back_to_back;
        int ack_cyc[4];
        logic [AW-1:0] a;
        post_req(1'b1, 19'h00400, 8'($urandom_range(0, 255)));
        tick();
        for (int i = 0; i < 4; i++) begin
            bit got = 0;
            for (int j = 0; j < 40 && !got; j++) begin
                if (dma_ack) got = 1;
                else tick();
            end
            ack_cyc[i] = cyc;
            if (!got) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL b2b_timeout: write %0d not acked", i);
            end
            if (i < 3) begin
                a = 19'h00400 + AW'(i + 1);
                post_req(1'b1, a, 8'($urandom_range(0, 255)));
            end else begin
                dma_req = 1'b0;
            end
            tick();
        end
        for (int i = 1; i < 4; i++) begin
            vec_cnt++;
            if (ack_cyc[i] - ack_cyc[i-1] !== 5) begin
                err_cnt++;
                $display("FAIL b2b_spacing%0d: %0d cycles, required 5", i, ack_cyc[i] - ack_cyc[i-1]);
            end
        end
        tick();
        for (int i = 0; i < 4; i++) do_dma(1'b0, 19'h00400 + AW'(i), 8'h00);
    endtask

    task automatic test_same_cycle;
        cpu_sel  = 1'b1;
        cpu_wr_n = 1'b1;
        cpu_addr = 19'h00010;
        post_req(1'b1, 19'h00500, 8'hC3);
        for (int k = 0; k < 3; k++) begin
            tick();
            vec_cnt++;
            if (busy !== 1'b0 || dma_ack !== 1'b0) begin
                err_cnt++;
                $display("FAIL same_cycle_wait%0d: busy=%b ack=%b required 0 0", k, busy, dma_ack);
            end
        end
        cpu_sel = 1'b0;
        tick();
        vec_cnt++;
        if (busy !== 1'b1 || ram_we_n !== 1'b0 || ram_a !== 19'h00500) begin
            err_cnt++;
            $display("FAIL same_cycle_start: busy=%b we=%b a=%h required 1 0 00500", busy, ram_we_n, ram_a);
        end
        wait_ack("same_cycle");
        do_dma(1'b0, 19'h00500, 8'h00);
    endtask

    task automatic test_reset_mid_strobe;
        int acks0;
        acks0      = ack_cnt;
        dma_wr     = 1'b1;
        dma_addr   = 19'h00600;
        dma_wrdata = 8'h5A;
        dma_req    = 1'b1;
        tick();
        #2;
        reset = 1'b1;
        #1;
        vec_cnt++;
        if ({ram_ce_n, ram_we_n, ram_oe_n, ram_d_oe, busy, dma_ack} !== 6'b111000) begin
            err_cnt++;
            $display("FAIL reset_mid_strobe: ce=%b we=%b oe=%b doe=%b busy=%b ack=%b required 1 1 1 0 0 0",
                     ram_ce_n, ram_we_n, ram_oe_n, ram_d_oe, busy, dma_ack);
        end
        dma_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        last_rd = 8'h00;
        vec_cnt++;
        if (ack_cnt !== acks0 || busy !== 1'b0 || dma_rddata !== 8'h00) begin
            err_cnt++;
            $display("FAIL reset_discard: acks=%0d busy=%b rd=%h required %0d 0 00",
                     ack_cnt, busy, dma_rddata, acks0);
        end
    endtask

    task automatic test_random;
        logic [AW-1:0] a;
        for (int i = 0; i < 6; i++) begin
            a = AW'($urandom_range(0, (1 << AW) - 1));
            do_dma(1'b1, a, 8'($urandom_range(0, 255)));
            do_dma(1'b0, a, 8'h00);
        end
    endtask

    initial begin
        reset        = 1'b1;
        cpu_sel      = 1'b0;
        cpu_wr_n     = 1'b1;
        cpu_wr_allow = 1'b0;
        cpu_addr     = '0;
        cpu_wrdata   = 8'h00;
        dma_req      = 1'b0;
        dma_wr       = 1'b0;
        dma_addr     = '0;
        dma_wrdata   = 8'h00;
        last_rd      = 8'h00;
        repeat (3) @(posedge clk);

        test_reset();
        test_dma_write_read();
        test_cpu_preempt();
        test_cpu_write_allow();
        test_back_to_back();
        test_same_cycle();
        test_reset_mid_strobe();
        test_random();

        repeat (3) tick();
        vec_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL queue_drain: %0d expected acks never arrived, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
